// File: rtl/control_sequencer_if.sv
// Signal bundle between the microcode sequencer and the datapath modules
// sharing the 8-bit tri-state bus.
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic              enable;
    logic [3:0]        opcode;
    logic              carry_flag;
    logic              zero_flag;
    logic [STEP_W-1:0] step;
    logic              halt;
    logic              mem_write_addr;
    logic              mem_write;
    logic              mem_read;
    logic              ir_write;
    logic              ir_read;
    logic              pc_inc;
    logic              pc_write;
    logic              pc_read;
    logic              a_write;
    logic              a_read;
    logic              b_write;
    logic              alu_read;
    logic              alu_sub;
    logic              flags_write;
    logic              out_write;

    modport master (
        input  enable, opcode, carry_flag, zero_flag,
        output step, halt, mem_write_addr, mem_write, mem_read, ir_write, ir_read,
               pc_inc, pc_write, pc_read, a_write, a_read, b_write, alu_read,
               alu_sub, flags_write, out_write
    );

    modport slave (
        output enable, opcode, carry_flag, zero_flag,
        input  step, halt, mem_write_addr, mem_write, mem_read, ir_write, ir_read,
               pc_inc, pc_write, pc_read, a_write, a_read, b_write, alu_read,
               alu_sub, flags_write, out_write
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: step counter plus halt latch,
// with a combinational decode of step/opcode/flags into bus control strobes.
module control_sequencer #(
    parameter int STEP_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic mem_write_addr;
        logic mem_write;
        logic mem_read;
        logic ir_write;
        logic ir_read;
        logic pc_inc;
        logic pc_write;
        logic pc_read;
        logic a_write;
        logic a_read;
        logic b_write;
        logic alu_read;
        logic alu_sub;
        logic flags_write;
        logic out_write;
    } strobes_t;

    localparam logic [STEP_W-1:0] T0 = '0;
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

    opcode_e           op;
    logic [STEP_W-1:0] step_q, step_d, last_step;
    logic              halted_q, halted_d;
    strobes_t          s;
    logic              halt_o;

    assign op = opcode_e'(bus.opcode);

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        last_step = T1;
        step_d    = step_q;
        halted_d  = halted_q;
        case (op)
            OP_LDA, OP_STA:                                 last_step = T3;
            OP_ADD, OP_SUB:                                 last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   last_step = T2;
            default:                                        last_step = T1;
        endcase
        if (halted_q) begin
            step_d = '0;
        end else if (bus.enable) begin
            // >= also recovers a step that is already past the end if the opcode changed mid-instruction
            step_d = (step_q >= last_step) ? '0 : step_q + T1;
            if (step_q == T2 && op == OP_HLT) halted_d = 1'b1;
        end
    end

    always_comb begin
        s      = '0;
        halt_o = halted_q;
        if (bus.enable && !halted_q) begin
            case (step_q)
                T0: begin
                    s.pc_read        = 1'b1;
                    s.mem_write_addr = 1'b1;
                end
                T1: begin
                    s.mem_read = 1'b1;
                    s.ir_write = 1'b1;
                    s.pc_inc   = 1'b1;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            s.ir_read        = 1'b1;
                            s.mem_write_addr = 1'b1;
                        end
                        OP_LDI: begin
                            s.ir_read = 1'b1;
                            s.a_write = 1'b1;
                        end
                        OP_JMP: begin
                            s.ir_read  = 1'b1;
                            s.pc_write = 1'b1;
                        end
                        OP_JC: begin
                            s.ir_read  = bus.carry_flag;
                            s.pc_write = bus.carry_flag;
                        end
                        OP_JZ: begin
                            s.ir_read  = bus.zero_flag;
                            s.pc_write = bus.zero_flag;
                        end
                        OP_OUT: begin
                            s.a_read    = 1'b1;
                            s.out_write = 1'b1;
                        end
                        OP_HLT:  halt_o = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            s.mem_read = 1'b1;
                            s.a_write  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            s.mem_read = 1'b1;
                            s.b_write  = 1'b1;
                        end
                        OP_STA: begin
                            s.a_read    = 1'b1;
                            s.mem_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        s.alu_read    = 1'b1;
                        s.a_write     = 1'b1;
                        s.flags_write = 1'b1;
                        s.alu_sub     = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.step           = step_q;
    assign bus.halt           = halt_o;
    assign bus.mem_write_addr = s.mem_write_addr;
    assign bus.mem_write      = s.mem_write;
    assign bus.mem_read       = s.mem_read;
    assign bus.ir_write       = s.ir_write;
    assign bus.ir_read        = s.ir_read;
    assign bus.pc_inc         = s.pc_inc;
    assign bus.pc_write       = s.pc_write;
    assign bus.pc_read        = s.pc_read;
    assign bus.a_write        = s.a_write;
    assign bus.a_read         = s.a_read;
    assign bus.b_write        = s.b_write;
    assign bus.alu_read       = s.alu_read;
    assign bus.alu_sub        = s.alu_sub;
    assign bus.flags_write    = s.flags_write;
    assign bus.out_write      = s.out_write;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a microprogram-table model checked every cycle,
// directed instruction walks with literal expectations, then random traffic.
module tb_control_sequencer;
    localparam logic [14:0] MWA  = 15'h4000;
    localparam logic [14:0] MW   = 15'h2000;
    localparam logic [14:0] MR   = 15'h1000;
    localparam logic [14:0] IRW  = 15'h0800;
    localparam logic [14:0] IRR  = 15'h0400;
    localparam logic [14:0] PCI  = 15'h0200;
    localparam logic [14:0] PCW  = 15'h0100;
    localparam logic [14:0] PCR  = 15'h0080;
    localparam logic [14:0] AW   = 15'h0040;
    localparam logic [14:0] AR   = 15'h0020;
    localparam logic [14:0] BW   = 15'h0010;
    localparam logic [14:0] ALUR = 15'h0008;
    localparam logic [14:0] SUB  = 15'h0004;
    localparam logic [14:0] FW   = 15'h0002;
    localparam logic [14:0] OW   = 15'h0001;
    localparam logic [14:0] F0   = MWA | PCR;
    localparam logic [14:0] F1   = MR | IRW | PCI;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    control_sequencer_if #(.STEP_W(3)) bus ();

    control_sequencer #(.STEP_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    logic [14:0] dut_vec;
    assign dut_vec = {bus.mem_write_addr, bus.mem_write, bus.mem_read, bus.ir_write,
                      bus.ir_read, bus.pc_inc, bus.pc_write, bus.pc_read, bus.a_write,
                      bus.a_read, bus.b_write, bus.alu_read, bus.alu_sub,
                      bus.flags_write, bus.out_write};

    // Microprogram table: strobes per (opcode, step) and instruction length.
    logic [14:0] prog [16][5];
    int          len  [16];

    initial begin
        for (int unsigned o = 0; o < 16; o++) begin
            prog[o][0] = F0;
            prog[o][1] = F1;
            prog[o][2] = '0;
            prog[o][3] = '0;
            prog[o][4] = '0;
            len[o]     = 2;
        end
        prog[1][2] = IRR | MWA;  prog[1][3] = MR | AW;                             len[1] = 4;
        prog[2][2] = IRR | MWA;  prog[2][3] = MR | BW;  prog[2][4] = ALUR | AW | FW;       len[2] = 5;
        prog[3][2] = IRR | MWA;  prog[3][3] = MR | BW;  prog[3][4] = ALUR | AW | FW | SUB; len[3] = 5;
        prog[4][2] = IRR | MWA;  prog[4][3] = AR | MW;                             len[4] = 4;
        prog[5][2] = IRR | AW;   len[5]  = 3;
        prog[6][2] = IRR | PCW;  len[6]  = 3;
        prog[7][2] = IRR | PCW;  len[7]  = 3;
        prog[8][2] = IRR | PCW;  len[8]  = 3;
        prog[14][2] = AR | OW;   len[14] = 3;
        len[15] = 3;
    end

    function automatic logic [14:0] model_vec(input int st, input logic [3:0] op,
                                              input logic c, input logic z,
                                              input logic en, input logic hlt);
        logic [14:0] v;
        if (!en || hlt || st > 4) return '0;
        v = prog[op][st];
        if (st == 2 && ((op == 4'h7 && !c) || (op == 4'h8 && !z))) v = '0;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    int   mdl_step   = 0;
    logic mdl_halted = 1'b0;
    logic mdl_valid  = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mdl_step   <= 0;
            mdl_halted <= 1'b0;
            mdl_valid  <= 1'b1;
        end else if (mdl_valid && bus.enable && !mdl_halted) begin
            if (bus.opcode == 4'hF && mdl_step == 2) mdl_halted <= 1'b1;
            mdl_step <= (mdl_step == len[bus.opcode] - 1) ? 0 : mdl_step + 1;
        end
    end

    always @(negedge clock) begin
        logic [14:0] ev;
        logic        eh;
        logic [2:0]  es;
        if (mdl_valid) begin
            ev = model_vec(mdl_step, bus.opcode, bus.carry_flag, bus.zero_flag,
                           bus.enable, mdl_halted);
            eh = mdl_halted || (bus.enable && mdl_step == 2 && bus.opcode == 4'hF);
            es = 3'(mdl_step);
            check("cycle", 32'({bus.step, bus.halt, dut_vec}), 32'({es, eh, ev}));
            check("rd_onehot", 32'($countones({bus.mem_read, bus.ir_read, bus.pc_read,
                                               bus.a_read, bus.alu_read}) <= 1), 32'd1);
            check("wr_onehot", 32'(!(bus.mem_write && bus.mem_write_addr)), 32'd1);
            check("sub_w_alu", 32'(!bus.alu_sub || bus.alu_read), 32'd1);
            check("step_lt5", 32'(bus.step < 3'd5), 32'd1);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic step_chk(input string nm, input logic [2:0] st, input logic [14:0] v,
                            input logic h);
        @(negedge clock);
        check(nm, 32'({bus.step, bus.halt, dut_vec}), 32'({st, h, v}));
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.opcode     = 4'h0;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;
        #1;
        check("model_add_t4", 32'(model_vec(4, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0)), 32'(ALUR | AW | FW));
        check("model_jc_nc",  32'(model_vec(2, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0)), 32'd0);
        check("model_len_sta", 32'(len[4]), 32'd4);

        tick(); tick();
        reset = 1'b0;
        step_chk("rst_t0",  3'd0, F0, 1'b0);
        step_chk("rst_t1",  3'd1, F1, 1'b0);
        step_chk("nop_t0",  3'd0, F0, 1'b0);
        step_chk("nop_t1",  3'd1, F1, 1'b0);

        bus.opcode = 4'h2;
        step_chk("add_t0", 3'd0, F0, 1'b0);
        step_chk("add_t1", 3'd1, F1, 1'b0);
        step_chk("add_t2", 3'd2, IRR | MWA, 1'b0);
        step_chk("add_t3", 3'd3, MR | BW, 1'b0);
        step_chk("add_t4", 3'd4, ALUR | AW | FW, 1'b0);
        bus.opcode = 4'h3;
        step_chk("sub_t0", 3'd0, F0, 1'b0);
        step_chk("sub_t1", 3'd1, F1, 1'b0);
        step_chk("sub_t2", 3'd2, IRR | MWA, 1'b0);
        step_chk("sub_t3", 3'd3, MR | BW, 1'b0);
        step_chk("sub_t4", 3'd4, ALUR | AW | FW | SUB, 1'b0);

        bus.opcode = 4'h7; bus.carry_flag = 1'b1;
        step_chk("jc1_t0", 3'd0, F0, 1'b0);
        step_chk("jc1_t1", 3'd1, F1, 1'b0);
        step_chk("jc1_t2", 3'd2, IRR | PCW, 1'b0);
        bus.carry_flag = 1'b0; bus.zero_flag = 1'b1;
        step_chk("jc0_t0", 3'd0, F0, 1'b0);
        step_chk("jc0_t1", 3'd1, F1, 1'b0);
        step_chk("jc0_t2", 3'd2, 15'h0, 1'b0);
        bus.opcode = 4'h8;
        step_chk("jz1_t0", 3'd0, F0, 1'b0);
        step_chk("jz1_t1", 3'd1, F1, 1'b0);
        step_chk("jz1_t2", 3'd2, IRR | PCW, 1'b0);
        bus.zero_flag = 1'b0; bus.carry_flag = 1'b1;
        step_chk("jz0_t0", 3'd0, F0, 1'b0);
        step_chk("jz0_t1", 3'd1, F1, 1'b0);
        step_chk("jz0_t2", 3'd2, 15'h0, 1'b0);

        bus.opcode = 4'hF;
        step_chk("hlt_t0", 3'd0, F0, 1'b0);
        step_chk("hlt_t1", 3'd1, F1, 1'b0);
        step_chk("hlt_t2", 3'd2, 15'h0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus.enable = (i % 4 != 3);
            bus.opcode = 4'(i);
            step_chk("halted", 3'd0, 15'h0, 1'b1);
        end
        bus.enable = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.opcode = 4'h1;
        step_chk("unhalt_t0", 3'd0, F0, 1'b0);
        step_chk("lda_t1", 3'd1, F1, 1'b0);
        step_chk("lda_t2", 3'd2, IRR | MWA, 1'b0);
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) step_chk("pause_t3", 3'd3, 15'h0, 1'b0);
        bus.enable = 1'b1;
        step_chk("resume_t3", 3'd3, MR | AW, 1'b0);
        step_chk("lda_wrap", 3'd0, F0, 1'b0);

        bus.opcode = 4'h2;
        step_chk("add2_t1", 3'd1, F1, 1'b0);
        step_chk("add2_t2", 3'd2, IRR | MWA, 1'b0);
        reset = 1'b1;
        step_chk("add2_t3", 3'd3, MR | BW, 1'b0);
        reset = 1'b0;
        step_chk("midrst_t0", 3'd0, F0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            reset = ($urandom_range(0, 39) == 0) || (mdl_halted && $urandom_range(0, 5) == 0);
            bus.enable     = ($urandom_range(0, 4) != 0);
            bus.carry_flag = 1'($urandom_range(0, 1));
            bus.zero_flag  = 1'($urandom_range(0, 1));
            if (mdl_step <= 1) bus.opcode = 4'($urandom_range(0, 15));
            tick();
        end
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
